// File: rtl/hdmi_blk_pkg.sv
// Shared types and geometry helpers for the raster <-> 8x8 block converters
// (hdmi_to_blocks and blocks_to_hdmi).
package hdmi_blk_pkg;

    localparam int unsigned BEAT_PIX = 2;

    typedef logic signed [7:0] pixel_t;

    // Beat layout at the default width; element 0 is the leftmost pixel.
    typedef struct packed {
        pixel_t [BEAT_PIX-1:0] y;
        pixel_t [BEAT_PIX-1:0] cr;
        pixel_t [BEAT_PIX-1:0] cb;
    } beat_t;

    typedef enum logic {
        RIdle,
        RRun
    } rd_state_e;

    function automatic int unsigned calc_bpl(int unsigned x_res, int unsigned n);
        return x_res / n;
    endfunction

    function automatic int unsigned calc_bpr(int unsigned n);
        return 8 / n;
    endfunction

    function automatic int unsigned calc_bpb(int unsigned n);
        return 64 / n;
    endfunction

    function automatic int unsigned calc_bps(int unsigned x_res);
        return x_res / 8;
    endfunction

    function automatic int unsigned clog2_min1(int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/stripe_ram.sv
// Simple dual-port inferred RAM: one write port, one read port, registered read.
module stripe_ram #(
    parameter int unsigned AW    = 8,
    parameter int unsigned WIDTH = 48
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/hdmi_to_blocks.sv
// Raster YCrCb stream to 8x8 blocks: one 8-line stripe is written into a ping-pong
// line RAM while the previous stripe is read back block by block.
module hdmi_to_blocks
    import hdmi_blk_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned X_RES = 2160,
    parameter int unsigned Y_RES = 1200
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           hdmi_v_sync,
    input  logic           hdmi_h_sync,
    input  logic           hdmi_data_valid,
    input  logic [N*8-1:0] hdmi_data_y,
    input  logic [N*8-1:0] hdmi_data_cr,
    input  logic [N*8-1:0] hdmi_data_cb,
    output logic           blk_valid,
    output logic [N*8-1:0] blk_data_y,
    output logic [N*8-1:0] blk_data_cr,
    output logic [N*8-1:0] blk_data_cb,
    output logic           blk_sob,
    output logic           blk_eob,
    output logic           blk_sof,
    output logic           err_overflow
);

    localparam int unsigned BPL     = calc_bpl(X_RES, N);
    localparam int unsigned BPR     = calc_bpr(N);
    localparam int unsigned BPB     = calc_bpb(N);
    localparam int unsigned BPS     = calc_bps(X_RES);
    localparam int unsigned NSTRIPE = Y_RES / 8;
    localparam int unsigned CW      = clog2_min1(BPL);
    localparam int unsigned BXW     = clog2_min1(BPS);
    localparam int unsigned BBW     = clog2_min1(BPB);
    localparam int unsigned SCW     = clog2_min1(NSTRIPE + 1);
    localparam int unsigned AW      = 4 + CW;
    localparam int unsigned PW      = N * 8;
    localparam int unsigned DW      = 3 * PW;

    // Write side state
    logic           vs_q, hs_q;
    logic           wbank;
    logic [2:0]     wline;
    logic [CW-1:0]  wcol;
    logic [SCW-1:0] stripe_cnt;
    logic           frame_start;
    logic [1:0]     sof_tag;
    logic [1:0]     ready;
    logic [1:0]     ready_set, ready_clr;

    logic vs_rise, hs_rise, frame_full, wr_en, line_end, stripe_done, ovf_hit;

    // Read side state
    rd_state_e      rstate;
    logic           rbank;
    logic [BXW-1:0] bx;
    logic [BBW-1:0] bb;
    logic [2:0]     rrow;
    logic [CW-1:0]  rcol;
    logic           rd_go, rd_at_last, rd_last;
    logic           iss_valid, iss_sob, iss_eob, iss_sof;
    logic [AW-1:0]  iss_addr;
    logic           p_valid, p_sob, p_eob, p_sof;
    logic [DW-1:0]  rdata;

    assign vs_rise     = hdmi_v_sync & ~vs_q;
    assign hs_rise     = hdmi_h_sync & ~hs_q;
    assign frame_full  = (stripe_cnt == SCW'(NSTRIPE));
    // Beats coinciding with a sync edge belong to blanking and are not stored.
    assign wr_en       = hdmi_data_valid & ~vs_rise & ~hs_rise & ~frame_full;
    assign line_end    = (wcol == CW'(BPL - 1));
    assign stripe_done = wr_en & line_end & (wline == 3'd7);
    assign ovf_hit     = stripe_done & (ready[~wbank] | ((rstate == RRun) & (rbank == ~wbank)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q         <= 1'b0;
            hs_q         <= 1'b0;
            wbank        <= 1'b0;
            wline        <= '0;
            wcol         <= '0;
            stripe_cnt   <= '0;
            frame_start  <= 1'b0;
            sof_tag      <= '0;
            err_overflow <= 1'b0;
        end else begin
            vs_q <= hdmi_v_sync;
            hs_q <= hdmi_h_sync;
            if (vs_rise) begin
                wline        <= '0;
                wcol         <= '0;
                stripe_cnt   <= '0;
                frame_start  <= 1'b1;
                err_overflow <= 1'b0;
            end else begin
                if (hs_rise && (wcol != '0)) begin
                    wcol         <= '0;
                    err_overflow <= 1'b1;
                end
                if (wr_en) begin
                    if ((wline == 3'd0) && (wcol == '0)) begin
                        sof_tag[wbank] <= frame_start;
                        frame_start    <= 1'b0;
                    end
                    if (line_end) begin
                        wcol  <= '0;
                        wline <= wline + 3'd1;
                        if (wline == 3'd7) begin
                            wbank      <= ~wbank;
                            stripe_cnt <= stripe_cnt + SCW'(1);
                        end
                    end else begin
                        wcol <= wcol + CW'(1);
                    end
                end
                if (ovf_hit) begin
                    err_overflow <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        ready_set = '0;
        ready_clr = '0;
        if (stripe_done) ready_set[wbank] = 1'b1;
        if (rd_last)     ready_clr[rbank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready <= '0;
        end else begin
            ready <= (ready & ~ready_clr) | ready_set;
        end
    end

    // Counters are zero whenever the reader idles, so an idle cycle that sees its
    // bank ready issues beat 0 straight away.
    assign rd_go      = (rstate == RRun) | ready[rbank];
    assign rd_at_last = (bx == BXW'(BPS - 1)) && (bb == BBW'(BPB - 1));
    assign rd_last    = rd_go & rd_at_last;
    assign rrow       = bb[BBW-1 -: 3];
    assign rcol       = CW'(bx) * CW'(BPR) + CW'(bb & BBW'(BPR - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate    <= RIdle;
            rbank     <= 1'b0;
            bx        <= '0;
            bb        <= '0;
            iss_valid <= 1'b0;
            iss_addr  <= '0;
            iss_sob   <= 1'b0;
            iss_eob   <= 1'b0;
            iss_sof   <= 1'b0;
        end else begin
            iss_valid <= rd_go;
            if (rd_go) begin
                iss_addr <= {rbank, rrow, rcol};
                iss_sob  <= (bb == '0);
                iss_eob  <= (bb == BBW'(BPB - 1));
                iss_sof  <= sof_tag[rbank] && (bx == '0) && (bb == '0);
                if (rd_at_last) begin
                    bx     <= '0;
                    bb     <= '0;
                    rbank  <= ~rbank;
                    rstate <= ready[~rbank] ? RRun : RIdle;
                end else begin
                    rstate <= RRun;
                    if (bb == BBW'(BPB - 1)) begin
                        bb <= '0;
                        bx <= bx + BXW'(1);
                    end else begin
                        bb <= bb + BBW'(1);
                    end
                end
            end else begin
                iss_sob <= 1'b0;
                iss_eob <= 1'b0;
                iss_sof <= 1'b0;
            end
        end
    end

    stripe_ram #(
        .AW    (AW),
        .WIDTH (DW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wbank, wline, wcol}),
        .wdata ({hdmi_data_y, hdmi_data_cr, hdmi_data_cb}),
        .re    (iss_valid),
        .raddr (iss_addr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid     <= 1'b0;
            p_sob       <= 1'b0;
            p_eob       <= 1'b0;
            p_sof       <= 1'b0;
            blk_valid   <= 1'b0;
            blk_sob     <= 1'b0;
            blk_eob     <= 1'b0;
            blk_sof     <= 1'b0;
            blk_data_y  <= '0;
            blk_data_cr <= '0;
            blk_data_cb <= '0;
        end else begin
            p_valid     <= iss_valid;
            p_sob       <= iss_sob;
            p_eob       <= iss_eob;
            p_sof       <= iss_sof;
            blk_valid   <= p_valid;
            blk_sob     <= p_sob;
            blk_eob     <= p_eob;
            blk_sof     <= p_sof;
            blk_data_y  <= rdata[DW-1 -: PW];
            blk_data_cr <= rdata[2*PW-1 -: PW];
            blk_data_cb <= rdata[PW-1:0];
        end
    end

endmodule

// File: doc/hdmi_to_blocks.md
Name: hdmi_to_blocks

Overview:
Input-side counterpart of blocks_to_hdmi. Takes a raster YCrCb pixel stream, N pixels per clock, and reorders it into 8x8 blocks for the JPEG block pipeline. Buffers one 8-line stripe in a ping-pong line RAM while the previous stripe is read out block by block. Its output interface is identical to the block input of blocks_to_hdmi, so the two can be chained directly.

Parameters:
N, 2, pixels per beat; must divide 8 (1, 2, 4, 8).
X_RES, 2160, active pixels per line; multiple of 8.
Y_RES, 1200, active lines per frame; multiple of 8.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
hdmi_v_sync  in  1  frame sync, active high; rising edge = new frame
hdmi_h_sync  in  1  line sync, active high; rising edge = new line
hdmi_data_valid  in  1  active pixel beat
hdmi_data_y  in  N*8  signed [N-1:0][7:0]; element 0 = leftmost pixel
hdmi_data_cr  in  N*8  as above
hdmi_data_cb  in  N*8  as above
blk_valid  out  1  block beat valid
blk_data_y  out  N*8  N pixels of one block row, element 0 leftmost
blk_data_cr  out  N*8  as above
blk_data_cb  out  N*8  as above
blk_sob  out  1  first beat of block
blk_eob  out  1  last beat of block
blk_sof  out  1  with sob of first block of frame
err_overflow  out  1  sticky error; cleared by reset or v_sync rising edge

Behaviour:
- Reset (async): all outputs 0. Counters, bank pointers and pending flags cleared; RAM contents undefined.
- Constants: BPL = X_RES/N (beats per line), BPR = 8/N (beats per block row), BPB = 64/N (beats per block), BPS = X_RES/8 (blocks per stripe).
- RAM: 2 banks x 8 lines x BPL words of 3*N*8 bits. Address = {bank, line[2:0], col}. 1 write port, 1 read port, 1-cycle read latency.
- Write side:
  - Each valid beat writes at (wbank, wline, wcol); wcol increments.
  - At wcol = BPL-1: wcol goes to 0 and wline increments.
  - At wline = 7 wrap: stripe complete. Raise ready[wbank], toggle wbank, increment the stripe count.
- Write side, sync events:
  - v_sync rising edge: wline, wcol and stripe count to 0; frame_start flag set; wbank not reset. A partially written stripe is discarded.
  - h_sync rising edge with wcol != 0: wcol to 0, wline unchanged, err_overflow set. The short line is dropped.
  - Beats after Y_RES/8 stripes in a frame are ignored until the next v_sync.
  - Each stripe records sof_tag = frame_start at its first beat; frame_start is then cleared.
- Read FSM:
  - R_IDLE: when ready[b] is set for the bank after the last bank read (rbank), go to R_RUN.
  - R_RUN: issues addresses in this order: block bx 0..BPS-1, row r 0..7, beat k 0..BPR-1; addr = {rbank, r, bx*BPR + k}. After the final address: clear ready[rbank], toggle rbank, go to R_IDLE (or straight back to R_RUN if the other bank is ready).
  - One beat is issued per cycle, with no gaps inside a stripe.
- Output pipeline:
  - Address issue, RAM read, output register. blk_* is valid 2 cycles after issue.
  - blk_sob at beat 0 of each block; blk_eob at beat BPB-1.
  - blk_sof with sob of block 0 of a stripe whose sof_tag = 1.
- Latency: first blk_valid of a stripe occurs 3 cycles after the clock edge that writes the stripe's last pixel (write/ready flag, FSM issue, RAM read, output register).
- Overflow:
  - A stripe completing while ready[wbank-after-toggle] is still set, or while R_RUN is reading that bank, sets err_overflow.
  - The stripe stays queued. Data may be corrupt; there is no other recovery.
- Throughput: a stripe drains in 8*BPL cycles, which is ≤ its fill time, so standard timing never overflows.
- Simultaneous write and read on the same address cannot occur in legal operation; RAM read-during-write is don't-care.

Decomposition:
- Package hdmi_blk_pkg:
  - pixel_t (signed 8-bit) and beat_t (N x pixel_t for Y/Cr/Cb).
  - BPR/BPB/BPS helper functions.
  - Shared with blocks_to_hdmi.
- Sub-module stripe_ram: simple dual-port inferred RAM, parameterised depth/width, registered read.

Test Plan:
All tests use N=2, X_RES=32, Y_RES=16, so BPL=16, BPB=32, BPS=4. Pixel value = (line*32 + x) mod 128, Y=Cr=Cb.
- One full frame, standard porches -> 8 blocks out. Block 0:
  - beat0 y = {1,0}, beat4 = {33,32}, beat31 = {231 mod 128 = 103, 102}.
  - sof only on block 0 beat 0; sob/eob every 32 beats.
  - err_overflow stays 0.
- Last write beat of stripe 0 at cycle T -> blk_valid first high at T+3. 128 consecutive valid beats follow with no gap.
- Two back-to-back frames -> blk_sof exactly twice, at the first block of each frame; stripe order preserved.
- h_sync mid-line after 5 beats -> err_overflow = 1. That line is dropped, and the next full line occupies the same wline.
- v_sync at wline = 3 of stripe 1 -> no blocks from the partial stripe. The next frame's block 0 carries sof; err_overflow cleared by the v_sync.
- Lines fed with no blanking (16 beats/line back-to-back) while the reader is held by a forced ready -> err_overflow = 1. Reset mid-readout -> all outputs 0 immediately.
